sb_corner_shadow_cfg: RTL
=========================

Name: sb_corner_shadow_cfg

Overview:
- Parametrised corner switch block for the top-right (bottom + left sides) tile position. It generalises the fixed 9-track, 2-input corner switch block to CHAN_WIDTH tracks per side.
- Each output mux gains an explicit "off" mode.
- A shadow/active configuration split lets the chain be reshifted while routing stays live. Configuration takes effect only on a validated commit.
- Sits in the routing fabric on the ccff configuration chain between neighbouring tiles.

Parameters:
- CHAN_WIDTH, 9: tracks per side (≥2); one output mux per track per side.
- TOTAL_BITS, 4*CHAN_WIDTH: derived localparam, not overridable; 2 bits per mux, 2*CHAN_WIDTH muxes.

Ports:
- prog_clk  in  1  configuration/fabric clock, rising edge
- prog_reset  in  1  synchronous, active-high reset
- ccff_head  in  1  config chain serial in
- cfg_en  in  1  shift enable; one bit is shifted per cycle while high
- cfg_commit  in  1  single-cycle pulse: copy shadow to active
- ccff_tail  out  1  config chain serial out
- cfg_loaded  out  1  exactly TOTAL_BITS shifted since last reset/commit, no overrun
- cfg_active  out  1  a valid configuration has been committed
- cfg_err  out  1  single-cycle pulse on a rejected commit
- chany_bottom_in  in  CHAN_WIDTH  bottom channel incoming tracks
- chanx_left_in  in  CHAN_WIDTH  left channel incoming tracks
- bottom_pin_in  in  CHAN_WIDTH  grid pins feeding bottom outputs
- left_pin_in  in  CHAN_WIDTH  grid pins feeding left outputs
- chany_bottom_out  out  CHAN_WIDTH  bottom channel driven tracks
- chanx_left_out  out  CHAN_WIDTH  left channel driven tracks

Behaviour:
- Clocking/reset: one clock, prog_clk. prog_reset is synchronous, active-high.
- Reset values:
  - shadow chain, active config, bit counter and overrun flag = 0
  - state = UNCFG
  - ccff_tail = 0, cfg_loaded = 0, cfg_active = 0, cfg_err = 0
  - all channel outputs = 0 (active code 00)
- Shadow chain, reg [0:TOTAL_BITS-1]:
  - When cfg_en=1: chain[0]<=ccff_head and chain[k]<=chain[k-1].
  - ccff_tail = chain[TOTAL_BITS-1] (registered). Latency head→tail = TOTAL_BITS cycles.
  - When cfg_en=0 the chain holds.
- Mux m takes code {chain[2m], chain[2m+1]}. m = 0..W-1 are bottom tracks 0..W-1; m = W..2W-1 are left tracks 0..W-1.
- Select codes (applied to active config only):
  - 00 → output 0
  - 01 → grid pin
  - 10 → cross track
  - 11 → output 0 (reserved)
- Routing, combinational from active config, zero latency:
  - chany_bottom_out[i] selects bottom_pin_in[i] or chanx_left_in[(i+1) mod W].
  - chanx_left_out[i] selects left_pin_in[i] or chany_bottom_in[(i-1+W) mod W].
- Bit counter, width $clog2(TOTAL_BITS+1):
  - Increments on each cfg_en cycle.
  - A shift while count==TOTAL_BITS sets a sticky overrun flag; the count then holds.
  - cfg_loaded = (count==TOTAL_BITS) && !overrun.
- FSM states: UNCFG, SHIFTING, LOADED, ACTIVE. Evaluated in this order each cycle:
  1. cfg_commit=1 with cfg_en=1 in the same cycle → commit rejected, cfg_err pulses, shift proceeds.
  2. cfg_commit=1 with cfg_loaded=1 → active<=shadow, count and overrun cleared, cfg_active<=1, state→ACTIVE. The shadow chain is retained.
  3. cfg_commit=1 otherwise → cfg_err pulses; active config, count and state are unchanged.
  4. cfg_en=1 → state SHIFTING (or LOADED once count reaches TOTAL_BITS).
- Shifting in ACTIVE: the active config and channel outputs are unaffected until the next successful commit. This is glitch-free reconfiguration. cfg_active stays 1.
- prog_reset mid-shift or mid-commit wins over all other inputs and restores all reset values.

Decomposition:
- Package sb_cfg_pkg holds:
  - select-code localparams SEL_OFF, SEL_PIN, SEL_TRK, SEL_RSV
  - state enum
  - function computing TOTAL_BITS from CHAN_WIDTH
- Sub-module sb_track_mux: 2-bit code, pin, track → out. It is instantiated 2*CHAN_WIDTH times via generate.

Test Plan:
- Reset:
  - Stimulus: assert prog_reset, drive all inputs 1.
  - Response: all outputs 0, cfg_loaded=0, cfg_active=0.
- Basic load/commit, W=9:
  - Stimulus: shift 36 bits so every code=01, then pulse commit.
  - Response: cfg_loaded=1 after the 36th shift; next cycle cfg_active=1 and chany_bottom_out==bottom_pin_in.
  - Follow-up: reshift all codes=10 and commit. Response: chany_bottom_out[8]==chanx_left_in[0] and chanx_left_out[0]==chany_bottom_in[8].
- Glitch-free reconfiguration:
  - Stimulus: while ACTIVE with codes 01, shift a new all-10 pattern.
  - Response: outputs unchanged every cycle until commit; switch on the commit+1 edge.
- Rejected commits:
  - Short: commit after 35 shifts → cfg_err one pulse, active unchanged.
  - Overrun: 37 shifts then commit → cfg_err pulse, cfg_loaded=0.
  - Simultaneous: commit with cfg_en=1 → cfg_err pulse.
- Chain passthrough:
  - Stimulus: shift pattern 1,0,0,…; count cycles.
  - Response: the 1 appears on ccff_tail after exactly 36 shifts. Code 11 drives output 0.
- Reset mid-shift:
  - Stimulus: prog_reset at shift 20, then a clean 36-bit load.
  - Response: count restarts from 0 and the commit succeeds. Repeat with CHAN_WIDTH=4 (16 bits).

Source files
------------

// File: rtl/sb_cfg_pkg.sv
// Shared definitions for the shadow-configured corner switch block:
// mux select codes, configuration FSM states and chain-length helper.
package sb_cfg_pkg;

  localparam logic [1:0] SEL_OFF = 2'b00;
  localparam logic [1:0] SEL_PIN = 2'b01;
  localparam logic [1:0] SEL_TRK = 2'b10;
  localparam logic [1:0] SEL_RSV = 2'b11;

  typedef enum logic [1:0] {
    UNCFG    = 2'd0,
    SHIFTING = 2'd1,
    LOADED   = 2'd2,
    ACTIVE   = 2'd3
  } cfg_state_e;

  // Two code bits per mux, one mux per track on each of the two sides.
  function automatic int total_bits(input int chan_width);
    return 4 * chan_width;
  endfunction

endpackage

// File: rtl/sb_track_mux.sv
// One routing output: selects off, grid pin or cross track from a 2-bit code.
module sb_track_mux
  import sb_cfg_pkg::*;
(
  input  logic [1:0] code,
  input  logic       pin,
  input  logic       track,
  output logic       route
);

  // The reserved code parks the output low, same as an explicit off.
  always_comb begin
    route = 1'b0;
    case (code)
      SEL_PIN: route = pin;
      SEL_TRK: route = track;
      SEL_OFF: route = 1'b0;
      SEL_RSV: route = 1'b0;
      default: route = 1'b0;
    endcase
  end

endmodule

// File: rtl/sb_corner_shadow_cfg.sv
// Top-right corner switch block (bottom + left sides) with a shadow config
// chain that only reaches the live routing on a validated commit.
module sb_corner_shadow_cfg
  import sb_cfg_pkg::*;
#(
  parameter int CHAN_WIDTH = 9
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  ccff_head,
  input  logic                  cfg_en,
  input  logic                  cfg_commit,
  output logic                  ccff_tail,
  output logic                  cfg_loaded,
  output logic                  cfg_active,
  output logic                  cfg_err,
  input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  input  logic [CHAN_WIDTH-1:0] bottom_pin_in,
  input  logic [CHAN_WIDTH-1:0] left_pin_in,
  output logic [CHAN_WIDTH-1:0] chany_bottom_out,
  output logic [CHAN_WIDTH-1:0] chanx_left_out
);

  localparam int TOTAL_BITS = total_bits(CHAN_WIDTH);
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:TOTAL_BITS-1] chain;
  logic [0:TOTAL_BITS-1] active;
  logic [CNT_W-1:0]      count;
  logic                  overrun;
  cfg_state_e            state;

  assign ccff_tail = chain[TOTAL_BITS-1];

  // LOADED is held exactly while count==TOTAL_BITS with no overrun.
  assign cfg_loaded = (state == LOADED);

  // A commit in a shift cycle is refused but the shift still goes ahead;
  // a successful commit keeps the shadow so it can be re-committed later.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      chain      <= '0;
      active     <= '0;
      count      <= '0;
      overrun    <= 1'b0;
      state      <= UNCFG;
      cfg_active <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_en) begin
        chain <= {ccff_head, chain[0:TOTAL_BITS-2]};
      end
      if (cfg_commit && !cfg_en) begin
        if (state == LOADED) begin
          active     <= chain;
          count      <= '0;
          overrun    <= 1'b0;
          cfg_active <= 1'b1;
          state      <= ACTIVE;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (cfg_en) begin
        cfg_err <= cfg_commit;
        if (count == CNT_FULL) begin
          overrun <= 1'b1;
          state   <= SHIFTING;
        end else begin
          count <= count + CNT_ONE;
          state <= (count == CNT_LAST) ? LOADED : SHIFTING;
        end
      end
    end
  end

  // Bottom track i crosses from left track i+1; left track i from bottom i-1.
  for (genvar i = 0; i < CHAN_WIDTH; i++) begin : g_track
    localparam int NEXT = (i + 1) % CHAN_WIDTH;
    localparam int PREV = (i + CHAN_WIDTH - 1) % CHAN_WIDTH;
    localparam int MB   = i;
    localparam int ML   = CHAN_WIDTH + i;

    sb_track_mux u_bottom (
      .code  ({active[2*MB], active[2*MB+1]}),
      .pin   (bottom_pin_in[i]),
      .track (chanx_left_in[NEXT]),
      .route (chany_bottom_out[i])
    );

    sb_track_mux u_left (
      .code  ({active[2*ML], active[2*ML+1]}),
      .pin   (left_pin_in[i]),
      .track (chany_bottom_in[PREV]),
      .route (chanx_left_out[i])
    );
  end

endmodule
